// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the Otter program-counter unit.
//   pc_sel_t   : PC source select codes (3 bits; codes 6/7 are reserved).
//   pc_state_t : trap FSM states.
//   PC_INC     : sequential instruction step in bytes.
package pc_pkg;

    localparam int PC_SEL_W = 3;
    localparam int PC_INC   = 4;

    typedef enum logic [PC_SEL_W-1:0] {
        PC_SEL_PLUS4  = 3'd0,
        PC_SEL_JALR   = 3'd1,
        PC_SEL_BRANCH = 3'd2,
        PC_SEL_JAL    = 3'd3,
        PC_SEL_MTVEC  = 3'd4,
        PC_SEL_MEPC   = 3'd5
    } pc_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: bundle between the control unit / branch-address generator
// (master) and the PC unit (slave).
//   master drives : pc_we, pc_sel, jalr, branch, jal, mtvec, mepc, intr
//   slave drives  : pc, pc_plus4, intr_ack, epc_we, epc_data, misalign, in_trap
interface pc_next_unit_if
    import pc_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                pc_we;
    logic [PC_SEL_W-1:0] pc_sel;
    logic [XLEN-1:0]     jalr;
    logic [XLEN-1:0]     branch;
    logic [XLEN-1:0]     jal;
    logic [XLEN-1:0]     mtvec;
    logic [XLEN-1:0]     mepc;
    logic                intr;

    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_plus4;
    logic                intr_ack;
    logic                epc_we;
    logic [XLEN-1:0]     epc_data;
    logic                misalign;
    logic                in_trap;

    modport master (
        output pc_we, pc_sel, jalr, branch, jal, mtvec, mepc, intr,
        input  pc, pc_plus4, intr_ack, epc_we, epc_data, misalign, in_trap
    );

    modport slave (
        input  pc_we, pc_sel, jalr, branch, jal, mtvec, mepc, intr,
        output pc, pc_plus4, intr_ack, epc_we, epc_data, misalign, in_trap
    );
endinterface

// File: rtl/pc_src_mux.sv
// pc_src_mux: combinational 6-way select of the next PC candidate.
//   sel      : pc_sel_t code; reserved codes 6/7 fall back to plus4
//   plus4, jalr, branch, jal, mtvec, mepc : candidate addresses
//   target   : selected address
module pc_src_mux
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [PC_SEL_W-1:0] sel,
    input  logic [XLEN-1:0]     plus4,
    input  logic [XLEN-1:0]     jalr,
    input  logic [XLEN-1:0]     branch,
    input  logic [XLEN-1:0]     jal,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     mepc,
    output logic [XLEN-1:0]     target
);
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        target = plus4;
        case (sel)
            PC_SEL_JALR:   target = jalr;
            PC_SEL_BRANCH: target = branch;
            PC_SEL_JAL:    target = jal;
            PC_SEL_MTVEC:  target = mtvec;
            PC_SEL_MEPC:   target = mepc;
            default:       target = plus4;
        endcase
    end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: Otter PC register, next-address select and two-state trap FSM.
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset (PC <- RESET_VEC, FSM <- RUN)
//   bus  : pc_next_unit_if.slave (controls, candidate targets, PC and trap outputs)
// Build option: define PC_MISALIGN_TRAP_EN to trap on a misaligned target
// instead of silently clearing its low two bits.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_next_unit_if.slave bus
);
    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_data_q, epc_data_d;
    logic            intr_ack_q, intr_ack_d;
    logic            epc_we_q, epc_we_d;
    logic            misalign_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] load_target;

    assign pc_plus4 = pc_q + XLEN'(PC_INC);

    pc_src_mux #(.XLEN(XLEN)) u_src_mux (
        .sel    (bus.pc_sel),
        .plus4  (pc_plus4),
        .jalr   (bus.jalr),
        .branch (bus.branch),
        .jal    (bus.jal),
        .mtvec  (bus.mtvec),
        .mepc   (bus.mepc),
        .target (target)
    );

`ifdef PC_MISALIGN_TRAP_EN
    // Misaligned targets never reach the PC; they divert to the trap below.
    assign load_target = target;
`else
    assign load_target = target & ~XLEN'(3);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next-state, next-PC and trap-pulse logic. Pulses default to 0 so they
    // drop on the next edge even when the unit is stalled.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_data_d = epc_data_q;
        intr_ack_d = 1'b0;
        epc_we_d   = 1'b0;
        misalign_d = 1'b0;
        if (bus.pc_we) begin
`ifdef PC_MISALIGN_TRAP_EN
            // Misalignment outranks an interrupt and also fires inside TRAP.
            if (target[1:0] != 2'b00) begin
                pc_d       = bus.mtvec;
                epc_data_d = pc_q;
                epc_we_d   = 1'b1;
                misalign_d = 1'b1;
                state_d    = TRAP;
            end else
`endif
            if (state_q == RUN && bus.intr) begin
                // Interrupt overrides PC_SEL; the skipped target is the return point.
                pc_d       = bus.mtvec;
                epc_data_d = load_target;
                epc_we_d   = 1'b1;
                intr_ack_d = 1'b1;
                state_d    = TRAP;
            end else begin
                pc_d = load_target;
                // Only MRET leaves TRAP; the same edge cannot also take an interrupt.
                if (state_q == TRAP && bus.pc_sel == PC_SEL_MEPC) state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            epc_data_q <= '0;
            intr_ack_q <= 1'b0;
            epc_we_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_data_q <= epc_data_d;
            intr_ack_q <= intr_ack_d;
            epc_we_q   <= epc_we_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = misalign_d & 1'b0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.intr_ack = intr_ack_q;
    assign bus.epc_we   = epc_we_q;
    assign bus.epc_data = epc_data_q;
    assign bus.in_trap  = (state_q == TRAP);
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-address unit for the Otter core. It is the parametrised successor to the combinational PC source mux. It holds the PC, computes PC+4 internally and selects among sequential, JALR, branch, JAL, trap-vector and trap-return targets. It also runs a two-state trap FSM that takes interrupts, blocks nesting until MRET, and produces the MEPC write for the CSR file. It sits between the control unit / branch-address generator and instruction memory.

## Interface
- XLEN, 32: address width.
- RESET_VEC, 0: PC value loaded on reset.
- CLK  in  1  core clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- PC_WE  in  1  advance enable; 0 = stall (PC, state, outputs hold).
- PC_SEL  in  3  0 PLUS_FOUR, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC (MRET); 6/7 reserved, treated as 0.
- JALR, BRANCH, JAL, MTVEC, MEPC  in  XLEN each  candidate targets.
- INTR  in  1  level interrupt request.
- PC  out  XLEN  current PC (registered).
- PC_PLUS4  out  XLEN  PC+4, combinational.
- INTR_ACK  out  1  one-cycle pulse: interrupt taken.
- EPC_WE  out  1  one-cycle pulse: CSR file writes EPC_DATA into mepc.
- EPC_DATA  out  XLEN  return address for the trap.
- MISALIGN  out  1  one-cycle pulse: misaligned target detected.
- IN_TRAP  out  1  FSM is in state TRAP.

## Operation
- Target = source selected by PC_SEL. PC_PLUS4 = PC + 4, computed modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0.
- FSM states: RUN, TRAP. Reset → RUN.
- RUN, PC_WE=1, INTR=0: PC ← target. A PC_SEL=4 load does not change state; a PC_SEL=5 load does not change state.
- RUN, PC_WE=1, INTR=1: the interrupt overrides PC_SEL.
  - PC ← MTVEC.
  - EPC_DATA ← the target that would have been loaded.
  - EPC_WE and INTR_ACK pulse.
  - State → TRAP.
- TRAP, PC_WE=1: normal sequencing. INTR is ignored (no nesting).
- TRAP, PC_SEL=5, PC_WE=1: PC ← MEPC, state → RUN. An INTR asserted in that same cycle is not taken; it is taken on the next enabled cycle if still high.
- PC_WE=0: nothing updates. INTR is not sampled.
- Reset (including mid-trap): PC=RESET_VEC, state RUN. INTR_ACK, EPC_WE, MISALIGN, IN_TRAP = 0. EPC_DATA = 0.

## Timing
- PC takes effect one edge after PC_WE=1. PC_PLUS4 has zero latency from PC.
- INTR_ACK, EPC_WE and EPC_DATA are registered. They assert in the cycle after the trap edge, coincident with PC==MTVEC, and deassert the following cycle even if stalled.
- IN_TRAP is registered and mirrors the state.
- MISALIGN is registered, one cycle.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A selected target with bits[1:0]≠0 is not loaded.
  - PC ← MTVEC, EPC_DATA ← current PC, EPC_WE and MISALIGN pulse.
  - From RUN, state → TRAP. From TRAP, state stays TRAP.
  - Misalign has priority over a simultaneous INTR; INTR_ACK stays 0.
- Undefined: target bits[1:0] are forced to 0 before loading. MISALIGN is tied 0.

## Structure
- Package pc_pkg: enum pc_sel_t (PC_SEL_PLUS4..PC_SEL_MEPC, 3 bits), enum pc_state_t {RUN, TRAP}, localparam PC_INC = 4.
- Sub-module pc_src_mux: combinational 6-way XLEN-wide select, reserved codes → PLUS_FOUR.
- FSM, PC register and trap-output registers live in pc_next_unit.

## Test plan
- Reset then four cycles PC_WE=1, PC_SEL=0 → PC 0, 4, 8, 12, 16. Assert RST mid-run → PC=0 immediately, IN_TRAP=0.
- PC=0x100, PC_SEL=3, JAL=0x200 → PC=0x200 next cycle. With PC_WE=0 → PC holds 0x100.
- RUN, PC=0x40, PC_SEL=2, BRANCH=0x80, INTR=1, MTVEC=0x1000 → PC=0x1000, EPC_DATA=0x80, EPC_WE=1, INTR_ACK=1, IN_TRAP=1 for one cycle then pulses clear.
- In TRAP with INTR held 1: several PLUS4 cycles show no second ACK. Then PC_SEL=5, MEPC=0x80 → PC=0x80, IN_TRAP=0. The next enabled cycle with INTR=1 → trap again.
- PC=0xFFFF_FFFC, PC_SEL=0 → PC=0x0.
- JALR=0x203, PC=0x10. With PC_MISALIGN_TRAP_EN → PC=MTVEC, EPC_DATA=0x10, MISALIGN=1. Without the macro → PC=0x200, MISALIGN=0.
